des_decrypt_iter: RTL and testbench

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

---
 rtl/des_pkg.sv | 102 ++++++++++
 rtl/des_key_sched_rev.sv | 37 +++
 rtl/des_decrypt_iter.sv | 87 ++++++++
 tb/tb_des_decrypt_iter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES permutation tables, reverse-order shift schedule and FSM state type.
// Bit vectors are MSB-first: DES bit n of a W-bit word lives at index W-n.
package des_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };

    localparam int E_TAB [48] = '{
        32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1
    };

    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17,  1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,   19, 13, 30, 6,  22, 11, 4,  25
    };

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    // Forward encryption schedule; decryption walks it backwards.
    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TAB[i]];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TAB[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TAB[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TAB[i]];
        return y;
    endfunction

    // Right-rotation applied after round rnd to reach the key of round rnd+1.
    function automatic logic [1:0] rev_shift(input logic [4:0] rnd);
        int idx;
        idx = 16 - int'(rnd);
        if (idx < 1 || idx > 15) return 2'd0;
        return 2'(SHIFT_TAB[idx]);
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_key_sched_rev.sv
// Reverse-order DES key schedule: C/D halves rotate right so subkeys
// emerge K16 first, K1 last.
module des_key_sched_rev
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [63:0] key,
    input  logic [4:0]  rnd,
    output logic [47:0] subkey
);

    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [55:0] cd_init;
    logic [1:0]  shift;

    assign cd_init = pc1_perm(key);
    assign shift   = rev_shift(rnd);
    assign subkey  = pc2_perm({c_q, d_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
        end else if (load) begin
            c_q <= cd_init[55:28];
            d_q <= cd_init[27:0];
        end else if (advance) begin
            c_q <= rotr28(c_q, shift);
            d_q <= rotr28(d_q, shift);
        end
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per cycle, S-boxes looked up
// externally through sbox_in/sbox_out.
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] din,
    input  logic [63:0] key,
    output logic [47:0] sbox_in,
    input  logic [31:0] sbox_out,
    output logic [63:0] dout,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e      state_q;
    logic [31:0] l_q;
    logic [31:0] r_q;
    logic [4:0]  rnd_q;
    logic [47:0] subkey;
    logic [63:0] ip_din;
    logic [31:0] r_next;
    logic        accept;
    logic        in_round;

    assign in_ready = (state_q == StIdle);
    assign in_round = (state_q == StRound);
    assign accept   = in_valid && in_ready;
    assign ip_din   = ip_perm(din);
    assign sbox_in  = in_round ? (e_expand(r_q) ^ subkey) : '0;
    assign r_next   = l_q ^ p_perm(sbox_out);

    des_key_sched_rev u_key_sched (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .advance (in_round),
        .key     (key),
        .rnd     (rnd_q),
        .subkey  (subkey)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            l_q       <= '0;
            r_q       <= '0;
            rnd_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        l_q     <= ip_din[63:32];
                        r_q     <= ip_din[31:0];
                        rnd_q   <= 5'd1;
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    l_q <= r_q;
                    r_q <= r_next;
                    if (rnd_q == 5'd16) begin
                        // Final round output is taken with the halves swapped.
                        dout      <= fp_perm({r_next, r_q});
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        rnd_q <= rnd_q + 5'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter with an S-box model and an
// expected-plaintext scoreboard.
module tb_des_decrypt_iter;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT_B  = 64'h0000000000000000;
    localparam logic [63:0] PT_B  = 64'h8787878787878787;

    localparam int SBOX [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
    };

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] din;
    logic [63:0] key;
    logic [47:0] sbox_in;
    logic [31:0] sbox_out;
    logic [63:0] dout;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] exp_q [$];

    des_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .key       (key),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sbox_fn(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  b;
        int          row;
        int          col;
        for (int k = 0; k < 8; k++) begin
            b   = x[47-6*k -: 6];
            row = int'({b[5], b[0]});
            col = int'(b[4:1]);
            y[31-4*k -: 4] = 4'(SBOX[k*64 + row*16 + col]);
        end
        return y;
    endfunction

    always_comb sbox_out = sbox_fn(sbox_in);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [63:0] k, input logic [63:0] exp);
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        din      = d;
        key      = k;
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        din      = {$urandom, $urandom};
        key      = {$urandom, $urandom};
        chk("in_ready_busy", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_out(input string tag, input int start_lat);
        int lat;
        lat = start_lat;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'd16);
        if (exp_q.size() == 0) chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
        else chk({tag, "_dout"}, dout, exp_q.pop_front());
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs_out_valid_low", 64'(out_valid), 64'd0);
        chk("hs_in_ready", 64'(in_ready), 64'd1);
        chk("hs_sbox_in_zero", 64'(sbox_in), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int          seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        key       = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_sbox_in", 64'(sbox_in), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Vector A, then hold off acceptance for five cycles.
        send(CT_A, KEY_A, PT_A);
        wait_out("vec_a", 0);
        held = dout;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_dout", dout, held);
        end
        handshake();

        send(CT_B, KEY_B, PT_B);
        wait_out("vec_b", 0);
        handshake();

        // Abort at round 8 by a one-cycle reset.
        send(CT_A, KEY_A, PT_A);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_dout_cleared", dout, 64'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_out_valid", 64'(seen), 64'd0);
        send(CT_B, KEY_B, PT_B);
        wait_out("after_abort", 0);
        handshake();

        // Second offer at round 5 must be ignored.
        send(CT_B, KEY_B, PT_B);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        din      = CT_A;
        key      = KEY_A;
        chk("pulse_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("ignored_pulse", 5);
        handshake();

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        send(CT_A, KEY_A, PT_A);
        wait_out("b2b_first", 0);
        @(negedge clk);
        send(CT_B, KEY_B, PT_B);
        wait_out("b2b_second", 0);
        @(negedge clk);
        chk("b2b_final_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
